serial_sum_collector: RTL

SERIAL_SUM_COLLECTOR -- requirements
Module: serial_sum_collector

---
 rtl/serial_sum_collector.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_sum_collector.sv
// Collects LSB-first serial sum bits from a bit-serial adder into a parallel word.
// Optional COLLECT_PARITY_EN adds out_parity, the XOR of the completed word.
module serial_sum_collector #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             csa_clr,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef COLLECT_PARITY_EN
  , output logic           out_parity
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-2:0] sr, sr_nx;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] data_nx;
  logic             valid_nx, clr_nx, busy_nx;

  // sr holds the first WIDTH-1 bits; the last bit is merged straight into out_data.
  assign shifted = {bit_in, sr};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    data_nx  = out_data;
    valid_nx = out_valid;
    clr_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = COLLECT;
          cnt_nx   = '0;
          sr_nx    = '0;
          clr_nx   = 1'b1;
        end
      end
      COLLECT: begin
        if (start) begin
          cnt_nx = '0;
          sr_nx  = '0;
          clr_nx = 1'b1;
        end else if (bit_valid) begin
          sr_nx  = shifted[WIDTH-1:1];
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state_nx = DONE;
            data_nx  = shifted;
            valid_nx = 1'b1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          if (start) begin
            state_nx = COLLECT;
            cnt_nx   = '0;
            sr_nx    = '0;
            clr_nx   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == COLLECT);
  end

  // csa_clr resets high so the upstream adder is cleared along with the collector.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sr        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      csa_clr   <= 1'b1;
    end else begin
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      csa_clr   <= clr_nx;
    end
  end

`ifdef COLLECT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else begin
      out_parity <= ^data_nx;
    end
  end
`endif

endmodule
